tdm_demux_4ch: RTL and testbench
================================

# tdm_demux_4ch

Dual-lane 4-channel time-division demultiplexer: the receive end of a link whose transmitter scans a dual 4:1 mux with a 2-bit select counter. It locks to a frame-sync pulse, tracks the slot number, captures one sample per slot into shadow registers, and publishes each complete 4-slot frame atomically to registered parallel outputs. Each lane has an active-low strobe with 74-series semantics: a slot captured with its strobe high stores 0.

## Interface
- DW, 1, data width per lane sample (1..16)
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_sync  in  1  frame sync; high on the cycle carrying slot 0
- i_1G_n  in  1  lane 1 strobe, active low
- i_2G_n  in  1  lane 2 strobe, active low
- i_1D  in  DW  lane 1 serial data
- i_2D  in  DW  lane 2 serial data
- o_1Y0..o_1Y3  out  DW each  lane 1 recovered channels
- o_2Y0..o_2Y3  out  DW each  lane 2 recovered channels
- o_1vld, o_2vld  out  1  one-cycle pulse: new frame on that lane's outputs
- o_sel  out  2  slot index of the sample taken this cycle
- o_lock  out  1  high in LOCK
- o_err  out  1  one-cycle pulse on sync violation

## Operation
- States: HUNT, LOCK. Reset -> HUNT.
- HUNT: o_sel = 0, nothing captured. When i_sync = 1, this cycle's data is slot 0: capture it, set slot = 1 for the next cycle, go to LOCK.
- LOCK: the slot counter increments every cycle and wraps 3 -> 0. Capture on every cycle.
- Capture: the shadow register for slot s of lane n loads i_nD if i_nG_n = 0 and loads 0 if i_nG_n = 1. Both lanes share the slot counter and sync.
- Frame complete: when slot 3 is captured and slots 0..2 of the same frame were captured since the last sync, copy the shadow slots 0..2 plus the slot-3 sample into o_nY0..3 for both lanes, and pulse o_1vld and o_2vld. Outputs change only at frame completion.
- Expected sync: at slot 0 in LOCK, i_sync = 1 is required.
  - If i_sync = 0 there: pulse o_err, go to HUNT, discard that sample.
- Spurious sync: i_sync = 1 at slot 1..3 in LOCK:
  - pulse o_err, discard the partial frame, treat this sample as slot 0 (next slot = 1), stay in LOCK.
- A spurious sync at slot 3 suppresses that frame's completion, so no vld pulse is issued.

## Timing
- Reset values: all o_nYk = 0, o_nvld = 0, o_err = 0, o_lock = 0, o_sel = 0, state HUNT, shadows 0.
- i_rst has priority over every other input on the same edge, including mid-frame; the partial frame is dropped.
- o_sel and o_lock are registered state and describe the current cycle's sample.
- Latency: the slot-3 sample is taken at edge T. o_nY0..3 and o_nvld are visible after edge T, and vld drops after T+1.
- Frame throughput: one frame per 4 cycles, continuous, no bubbles.
- o_err is asserted for one cycle, after the edge that sampled the violation.
- Sync in HUNT: first vld occurs 3 cycles after the sync edge.

## Structure
- Package tdm_pkg:
  - state enum {HUNT, LOCK}
  - localparam SLOTS = 4
  - localparam SLOT_W = 2
- Sub-module tdm_lane: one lane's strobe gating, 3 shadow registers and 4 output registers. It takes slot, capture-enable, discard and publish controls and is instantiated twice. The top level holds the FSM, slot counter and error logic.

## Test plan
- Reset, then idle with i_sync = 0 for 10 cycles -> o_lock = 0, all outputs 0, no vld, no err.
- DW=1, strobes low, sync at cycle 0, lane 1 data 1,0,0,1 and lane 2 data 0,1,1,0 -> after cycle-3 edge o_1Y0..3 = 1,0,0,1, o_2Y0..3 = 0,1,1,0, o_1vld = o_2vld = 1 for one cycle.
- Same frame with i_1G_n = 1 during slot 2 only -> o_1Y2 = 0, other lane 1 bits as sent, lane 2 unaffected.
- Locked stream, sync withheld at next slot 0 -> o_err pulse, o_lock = 0, outputs hold the previous frame, no vld until a new sync plus 4 slots.
- Sync at slot 2 of a frame -> o_err pulse, no vld for the broken frame, then vld exactly 3 cycles after the spurious sync.
- i_rst asserted at slot 2 -> next cycle all outputs 0, HUNT; a subsequent sync yields a clean frame.

Source files
------------

// File: rtl/tdm_pkg.sv
// ============================================================================
// Module : tdm_pkg
// Brief  : Shared types and constants for the 4-channel TDM demultiplexer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tdm_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tdm_demux_4ch_lane.sv
// ============================================================================
// Module : tdm_lane
// Brief  : One demux lane: strobe gating, slot 0..2 shadows, published outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_lane
    import tdm_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_g_n,
    input  logic [DW-1:0]     i_d,
    input  logic [SLOT_W-1:0] i_slot,
    input  logic              i_capture,
    input  logic              i_discard,
    input  logic              i_publish,
    output logic [DW-1:0]     o_y0,
    output logic [DW-1:0]     o_y1,
    output logic [DW-1:0]     o_y2,
    output logic [DW-1:0]     o_y3,
    output logic              o_vld
);

    logic [DW-1:0] w_sample;
    logic [DW-1:0] r_shadow [0:SLOTS-2];
    logic [DW-1:0] r_y      [0:SLOTS-1];
    logic          r_vld;

    // A strobed-off slot stores zero rather than holding its old value.
    assign w_sample = i_g_n ? '0 : i_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < SLOTS - 1; k++) r_shadow[k] <= '0;
            for (int k = 0; k < SLOTS; k++)     r_y[k]      <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= i_publish;
            // Discard first; a same-cycle slot-0 capture overrides it.
            if (i_discard) begin
                for (int k = 0; k < SLOTS - 1; k++) r_shadow[k] <= '0;
            end
            for (int k = 0; k < SLOTS - 1; k++) begin
                if (i_capture && (i_slot == SLOT_W'(k))) r_shadow[k] <= w_sample;
            end
            if (i_publish) begin
                for (int k = 0; k < SLOTS - 1; k++) r_y[k] <= r_shadow[k];
                r_y[SLOTS-1] <= w_sample;
            end
        end
    end

    assign o_y0  = r_y[0];
    assign o_y1  = r_y[1];
    assign o_y2  = r_y[2];
    assign o_y3  = r_y[3];
    assign o_vld = r_vld;

endmodule

`default_nettype wire

// File: rtl/tdm_demux_4ch.sv
// ============================================================================
// Module : tdm_demux_4ch
// Brief  : Dual-lane 4-channel TDM demux with frame-sync lock and atomic publish.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sync,
    input  logic          i_1G_n,
    input  logic          i_2G_n,
    input  logic [DW-1:0] i_1D,
    input  logic [DW-1:0] i_2D,
    output logic [DW-1:0] o_1Y0,
    output logic [DW-1:0] o_1Y1,
    output logic [DW-1:0] o_1Y2,
    output logic [DW-1:0] o_1Y3,
    output logic [DW-1:0] o_2Y0,
    output logic [DW-1:0] o_2Y1,
    output logic [DW-1:0] o_2Y2,
    output logic [DW-1:0] o_2Y3,
    output logic          o_1vld,
    output logic          o_2vld,
    output logic [1:0]    o_sel,
    output logic          o_lock,
    output logic          o_err
);

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic                r_err;

    state_t              w_state_nxt;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [SLOT_W-1:0]   w_cap_slot;
    logic                w_capture;
    logic                w_discard;
    logic                w_publish;
    logic                w_err;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_cap_slot  = r_slot;
        w_capture   = 1'b0;
        w_discard   = 1'b0;
        w_publish   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            HUNT: begin
                if (i_sync) begin
                    w_capture   = 1'b1;
                    w_discard   = 1'b1;
                    w_cap_slot  = '0;
                    w_slot_nxt  = SLOT_W'(1);
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (r_slot == '0) begin
                    if (i_sync) begin
                        w_capture  = 1'b1;
                        w_slot_nxt = SLOT_W'(1);
                    end else begin
                        // Missing sync: drop the sample and fall back to hunting.
                        w_err       = 1'b1;
                        w_discard   = 1'b1;
                        w_slot_nxt  = '0;
                        w_state_nxt = HUNT;
                    end
                end else if (i_sync) begin
                    // Early sync restarts the frame at slot 0; no publish this cycle.
                    w_err      = 1'b1;
                    w_discard  = 1'b1;
                    w_capture  = 1'b1;
                    w_cap_slot = '0;
                    w_slot_nxt = SLOT_W'(1);
                end else begin
                    w_capture  = 1'b1;
                    w_publish  = (r_slot == SLOT_W'(SLOTS - 1));
                    w_slot_nxt = r_slot + SLOT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= HUNT;
            r_slot  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_err   <= w_err;
        end
    end

    assign o_sel  = r_slot;
    assign o_lock = (r_state == LOCK);
    assign o_err  = r_err;

    tdm_lane #(.DW(DW)) u_lane1 (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_g_n     (i_1G_n),
        .i_d       (i_1D),
        .i_slot    (w_cap_slot),
        .i_capture (w_capture),
        .i_discard (w_discard),
        .i_publish (w_publish),
        .o_y0      (o_1Y0),
        .o_y1      (o_1Y1),
        .o_y2      (o_1Y2),
        .o_y3      (o_1Y3),
        .o_vld     (o_1vld)
    );

    tdm_lane #(.DW(DW)) u_lane2 (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_g_n     (i_2G_n),
        .i_d       (i_2D),
        .i_slot    (w_cap_slot),
        .i_capture (w_capture),
        .i_discard (w_discard),
        .i_publish (w_publish),
        .o_y0      (o_2Y0),
        .o_y1      (o_2Y1),
        .o_y2      (o_2Y2),
        .o_y3      (o_2Y3),
        .o_vld     (o_2vld)
    );

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_4ch.sv
// ============================================================================
// Module : tb_tdm_demux_4ch
// Brief  : Directed plus randomized bench for tdm_demux_4ch with a frame model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_4ch;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst, sync, g1, g2;
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] y10, y11, y12, y13, y20, y21, y22, y23;
    logic          vld1, vld2, lock, err;
    logic [1:0]    sel;

    always #5 clk = ~clk;

    tdm_demux_4ch #(.DW(DW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_sync (sync),
        .i_1G_n (g1),
        .i_2G_n (g2),
        .i_1D   (d1),
        .i_2D   (d2),
        .o_1Y0  (y10),
        .o_1Y1  (y11),
        .o_1Y2  (y12),
        .o_1Y3  (y13),
        .o_2Y0  (y20),
        .o_2Y1  (y21),
        .o_2Y2  (y22),
        .o_2Y3  (y23),
        .o_1vld (vld1),
        .o_2vld (vld2),
        .o_sel  (sel),
        .o_lock (lock),
        .o_err  (err)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model: locked flag, expected slot, run length since sync.
    bit            m_lock;
    int            m_slot;
    int            m_have;
    logic [DW-1:0] sh1 [4];
    logic [DW-1:0] sh2 [4];
    logic [DW-1:0] ey1 [4];
    logic [DW-1:0] ey2 [4];
    bit            e_vld, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_slot = 0; m_have = 0; e_vld = 0; e_err = 0;
        for (int k = 0; k < 4; k++) begin
            sh1[k] = '0; sh2[k] = '0; ey1[k] = '0; ey2[k] = '0;
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit ga, input bit gb,
                              input logic [DW-1:0] da, input logic [DW-1:0] db);
        logic [DW-1:0] v1, v2;
        v1 = ga ? '0 : da;
        v2 = gb ? '0 : db;
        e_vld = 0;
        e_err = 0;
        if (r) begin
            model_reset();
        end else if (!m_lock) begin
            if (s) begin
                sh1[0] = v1; sh2[0] = v2; m_have = 1; m_lock = 1; m_slot = 1;
            end
        end else if (m_slot == 0) begin
            if (s) begin
                sh1[0] = v1; sh2[0] = v2; m_have = 1; m_slot = 1;
            end else begin
                e_err = 1; m_lock = 0; m_have = 0; m_slot = 0;
            end
        end else if (s) begin
            e_err = 1; sh1[0] = v1; sh2[0] = v2; m_have = 1; m_slot = 1;
        end else begin
            sh1[m_slot] = v1; sh2[m_slot] = v2;
            m_have++;
            if (m_slot == 3 && m_have == 4) begin
                for (int k = 0; k < 4; k++) begin ey1[k] = sh1[k]; ey2[k] = sh2[k]; end
                e_vld = 1;
            end
            m_slot = (m_slot + 1) % 4;
        end
    endtask

    function automatic logic [31:0] pk1();
        return 32'({y13, y12, y11, y10});
    endfunction

    function automatic logic [31:0] pk2();
        return 32'({y23, y22, y21, y20});
    endfunction

    task automatic step(input bit r, input bit s, input bit ga, input bit gb,
                        input logic [DW-1:0] da, input logic [DW-1:0] db);
        @(negedge clk);
        rst = r; sync = s; g1 = ga; g2 = gb; d1 = da; d2 = db;
        @(posedge clk);
        #1;
        model_edge(r, s, ga, gb, da, db);
        chk("sel",  32'(sel),  m_lock ? 32'(m_slot) : 32'd0);
        chk("lock", 32'(lock), 32'(m_lock));
        chk("err",  32'(err),  32'(e_err));
        chk("vld1", 32'(vld1), 32'(e_vld));
        chk("vld2", 32'(vld2), 32'(e_vld));
        chk("y1",   pk1(),     32'({ey1[3], ey1[2], ey1[1], ey1[0]}));
        chk("y2",   pk2(),     32'({ey2[3], ey2[2], ey2[1], ey2[0]}));
    endtask

    initial begin
        bit            r, s;
        rst = 1; sync = 0; g1 = 0; g2 = 0; d1 = '0; d2 = '0;
        model_reset();

        // Reset, then idle without sync.
        step(1, 0, 0, 0, 4'h0, 4'h0);
        step(1, 0, 0, 0, 4'h0, 4'h0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'(i), 4'(i + 3));
        chk("idle_lock", 32'(lock), 32'd0);

        // First frame from HUNT.
        step(0, 1, 0, 0, 4'h1, 4'h0);
        step(0, 0, 0, 0, 4'h0, 4'h1);
        step(0, 0, 0, 0, 4'h0, 4'h1);
        step(0, 0, 0, 0, 4'h1, 4'h0);
        chk("f1_y1",  pk1(), 32'h1001);
        chk("f1_y2",  pk2(), 32'h0110);
        chk("f1_vld", 32'(vld1 & vld2), 32'd1);

        // Lane-1 strobe off during slot 2.
        step(0, 1, 0, 0, 4'h0, 4'h1);
        chk("f2_vld_drop", 32'(vld1), 32'd0);
        step(0, 0, 0, 0, 4'h1, 4'h1);
        step(0, 0, 1, 0, 4'hF, 4'h1);
        step(0, 0, 0, 0, 4'h1, 4'h0);
        chk("f2_y1", pk1(), 32'h1010);
        chk("f2_y2", pk2(), 32'h0111);

        // Sync withheld at slot 0.
        step(0, 0, 0, 0, 4'h7, 4'h7);
        chk("miss_err",  32'(err),  32'd1);
        chk("miss_lock", 32'(lock), 32'd0);
        chk("miss_hold", pk1(),     32'h1010);
        step(0, 0, 0, 0, 4'h7, 4'h7);

        // Spurious sync at slot 2, then vld exactly 3 cycles later.
        step(0, 1, 0, 0, 4'h2, 4'h3);
        step(0, 0, 0, 0, 4'h4, 4'h5);
        step(0, 1, 0, 0, 4'h6, 4'h7);
        chk("spur_err", 32'(err), 32'd1);
        step(0, 0, 0, 0, 4'h8, 4'h9);
        step(0, 0, 0, 0, 4'hA, 4'hB);
        chk("spur_novld", 32'(vld1), 32'd0);
        step(0, 0, 0, 0, 4'hC, 4'hD);
        chk("spur_vld", 32'(vld1), 32'd1);
        chk("spur_y1",  pk1(),     32'hCA86);

        // Reset mid-frame at slot 2, then a clean frame.
        step(0, 1, 0, 0, 4'h1, 4'h2);
        step(0, 0, 0, 0, 4'h3, 4'h4);
        step(1, 0, 0, 0, 4'h5, 4'h6);
        chk("rst_y1",   pk1(),      32'd0);
        chk("rst_lock", 32'(lock),  32'd0);
        step(0, 1, 0, 0, 4'h9, 4'h8);
        step(0, 0, 0, 0, 4'h7, 4'h6);
        step(0, 0, 0, 0, 4'h5, 4'h4);
        step(0, 0, 0, 0, 4'h3, 4'h2);
        chk("post_rst_y2", pk2(), 32'h2468);

        // Randomized stream, mostly well-formed with occasional faults.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 149) == 0);
            if (m_lock && m_slot == 0) s = ($urandom_range(0, 15) != 0);
            else if (!m_lock)          s = ($urandom_range(0, 3) == 0);
            else                       s = ($urandom_range(0, 24) == 0);
            step(r, s, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 4'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
